chess_fb_renderer: RTL

- Frame-buffer writer feeding port A of the 2-port pixel RAM. The VGA RGB stage scans that RAM out on port B.
- On a start pulse, snapshots the 8x8 board state and rasterises one full 640x480 frame of 24-bit RGB into the RAM.
- Each pixel is one write, in raster order, at address y*SCREEN_WIDTH+x.

---
 rtl/chess_fb_renderer_pkg.sv | 29 ++
 rtl/chess_fb_renderer_if.sv | 12 +
 rtl/chess_fb_renderer_shader.sv | 36 +++
 rtl/chess_fb_renderer.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/chess_fb_renderer_pkg.sv
// Shared graphics types, palette, FSM encoding and default frame geometry for the chess renderer.
package chess_gfx_pkg;

  localparam int DEFAULT_SCREEN_WIDTH  = 640;
  localparam int DEFAULT_SCREEN_HEIGHT = 480;
  localparam int DEFAULT_SQUARE_SIZE   = 60;
  localparam int DEFAULT_BOARD_X0      = 80;
  localparam int DEFAULT_PIECE_INSET   = 15;
  localparam int COLOR_DEPTH           = 8;
  localparam int CURSOR_BAND           = 3;

  typedef logic [3*COLOR_DEPTH-1:0] rgb_t;
  typedef logic [3:0]               piece_t;

  localparam rgb_t SQ_LIGHT    = 24'hEED2AA;
  localparam rgb_t SQ_DARK     = 24'h8B5A2B;
  localparam rgb_t BORDER      = 24'h202020;
  localparam rgb_t PIECE_WHITE = 24'hFFFFFF;
  localparam rgb_t PIECE_BLACK = 24'h000000;
  localparam rgb_t CURSOR      = 24'hFFFF00;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SNAP = 2'd1,
    ST_DRAW = 2'd2,
    ST_FIN  = 2'd3
  } fsm_state_e;

endpackage

// File: rtl/chess_fb_renderer_if.sv
// Pixel RAM write port: the renderer drives address/data/enable, the RAM side answers with ready.
interface chess_fb_renderer_if;
  import chess_gfx_pkg::*;

  logic [18:0] wr_addr;
  rgb_t        wr_data;
  logic        wr_en;
  logic        wr_ready;

  modport master (output wr_addr, output wr_data, output wr_en, input wr_ready);
  modport slave  (input wr_addr, input wr_data, input wr_en, output wr_ready);
endinterface

// File: rtl/chess_fb_renderer_shader.sv
// Combinational colour select for one pixel; border beats cursor, cursor beats piece, piece beats square.
module chess_pixel_shader
  import chess_gfx_pkg::*;
#(
  parameter int SQUARE_SIZE = DEFAULT_SQUARE_SIZE,
  parameter int PIECE_INSET = DEFAULT_PIECE_INSET
) (
  input  logic       in_board,
  input  logic [2:0] row,
  input  logic [2:0] col,
  input  logic [5:0] sub_x,
  input  logic [5:0] sub_y,
  input  piece_t     piece,
  input  logic       cursor_hit,
  output rgb_t       rgb
);

  localparam logic [5:0] InsetLo = 6'(PIECE_INSET);
  localparam logic [5:0] InsetHi = 6'(SQUARE_SIZE - PIECE_INSET);

  logic inMarker;

  always_comb begin
    inMarker = (sub_x >= InsetLo) && (sub_x < InsetHi) &&
               (sub_y >= InsetLo) && (sub_y < InsetHi);
    rgb = (row[0] ^ col[0]) ? SQ_DARK : SQ_LIGHT;
    if (!in_board) begin
      rgb = BORDER;
    end else if (cursor_hit) begin
      rgb = CURSOR;
    end else if (inMarker && (piece[2:0] != 3'd0)) begin
      rgb = piece[3] ? PIECE_BLACK : PIECE_WHITE;
    end
  end

endmodule

// File: rtl/chess_fb_renderer.sv
// Rasterises a snapshot of the 8x8 board into the frame buffer, one pixel write per accepted handshake.
// Optional cursor outline around the latched cursor square is enabled by defining CURSOR_HIGHLIGHT_EN.
module chess_fb_renderer #(
  parameter int SCREEN_WIDTH  = chess_gfx_pkg::DEFAULT_SCREEN_WIDTH,
  parameter int SCREEN_HEIGHT = chess_gfx_pkg::DEFAULT_SCREEN_HEIGHT,
  parameter int SQUARE_SIZE   = chess_gfx_pkg::DEFAULT_SQUARE_SIZE,
  parameter int BOARD_X0      = chess_gfx_pkg::DEFAULT_BOARD_X0,
  parameter int PIECE_INSET   = chess_gfx_pkg::DEFAULT_PIECE_INSET
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [255:0]         board_state,
  input  logic [5:0]           cursor_sq,
  chess_fb_renderer_if.master  wr,
  output logic                 busy,
  output logic                 done
);
  import chess_gfx_pkg::*;

  localparam logic [1:0]  S_IDLE   = ST_IDLE;
  localparam logic [1:0]  S_SNAP   = ST_SNAP;
  localparam logic [1:0]  S_DRAW   = ST_DRAW;
  localparam logic [1:0]  S_FIN    = ST_FIN;
  localparam logic [9:0]  XLast    = 10'(SCREEN_WIDTH - 1);
  localparam logic [9:0]  BoardXLo = 10'(BOARD_X0);
  localparam logic [9:0]  BoardXHi = 10'(BOARD_X0 + 8*SQUARE_SIZE);
  localparam logic [8:0]  BoardYHi = 9'(8*SQUARE_SIZE);
  localparam logic [5:0]  SubLast  = 6'(SQUARE_SIZE - 1);
  localparam logic [18:0] AddrLast = 19'(SCREEN_WIDTH*SCREEN_HEIGHT - 1);

  logic [1:0]   state_q, state_d;
  logic [255:0] board_q, board_d;
  logic [9:0]   pixX_q, pixX_d;
  logic [8:0]   pixY_q, pixY_d;
  logic [18:0]  addr_q, addr_d;
  logic [2:0]   col_q, col_d, row_q, row_d;
  logic [5:0]   subX_q, subX_d, subY_q, subY_d;
  logic [18:0]  wrAddr_q, wrAddr_d;
  rgb_t         wrData_q, wrData_d;
  logic         wrEn_q, wrEn_d;

  logic         lineEnd, inBoardX, inBoardY, inBoard, cursorHit, load;
  logic [9:0]   stepX;
  logic [8:0]   stepY;
  logic [2:0]   stepCol, stepRow;
  logic [5:0]   stepSubX, stepSubY;
  piece_t       pieceSel;
  rgb_t         shadeRgb;

  // Square and sub-pixel positions follow the raster with wrap counters instead of a divider.
  always_comb begin
    lineEnd  = (pixX_q == XLast);
    inBoardX = (pixX_q >= BoardXLo) && (pixX_q < BoardXHi);
    inBoardY = (pixY_q < BoardYHi);
    inBoard  = inBoardX && inBoardY;
    stepX    = lineEnd ? 10'd0 : pixX_q + 10'd1;
    stepY    = pixY_q;
    stepSubX = subX_q;
    stepCol  = col_q;
    stepSubY = subY_q;
    stepRow  = row_q;
    if (lineEnd) begin
      stepSubX = '0;
      stepCol  = '0;
      stepY    = pixY_q + 9'd1;
      if (inBoardY) begin
        if (subY_q == SubLast) begin
          stepSubY = '0;
          stepRow  = row_q + 3'd1;
        end else begin
          stepSubY = subY_q + 6'd1;
        end
      end
    end else if (inBoardX) begin
      if (subX_q == SubLast) begin
        stepSubX = '0;
        stepCol  = col_q + 3'd1;
      end else begin
        stepSubX = subX_q + 6'd1;
      end
    end
  end

  assign pieceSel = board_q[{row_q, col_q, 2'b00} +: 4];

`ifdef CURSOR_HIGHLIGHT_EN
  logic [5:0] cursor_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cursor_q <= '0;
    end else if ((state_q == S_IDLE) && start) begin
      cursor_q <= cursor_sq;
    end
  end

  assign cursorHit = inBoard && ({row_q, col_q} == cursor_q) &&
                     ((subX_q < 6'(CURSOR_BAND)) || (subX_q >= 6'(SQUARE_SIZE - CURSOR_BAND)) ||
                      (subY_q < 6'(CURSOR_BAND)) || (subY_q >= 6'(SQUARE_SIZE - CURSOR_BAND)));
`else
  logic unusedCursor;
  assign unusedCursor = ^cursor_sq;
  assign cursorHit    = 1'b0;
`endif

  chess_pixel_shader #(
    .SQUARE_SIZE (SQUARE_SIZE),
    .PIECE_INSET (PIECE_INSET)
  ) u_shader (
    .in_board   (inBoard),
    .row        (row_q),
    .col        (col_q),
    .sub_x      (subX_q),
    .sub_y      (subY_q),
    .piece      (pieceSel),
    .cursor_hit (cursorHit),
    .rgb        (shadeRgb)
  );

  // The output slot is refilled only when empty (SNAP) or its pixel was just accepted, so a stall freezes it.
  always_comb begin
    state_d  = state_q;
    board_d  = board_q;
    pixX_d   = pixX_q;
    pixY_d   = pixY_q;
    addr_d   = addr_q;
    col_d    = col_q;
    row_d    = row_q;
    subX_d   = subX_q;
    subY_d   = subY_q;
    wrAddr_d = wrAddr_q;
    wrData_d = wrData_q;
    wrEn_d   = wrEn_q;
    load     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_SNAP;
          board_d = board_state;
          pixX_d  = '0;
          pixY_d  = '0;
          addr_d  = '0;
          col_d   = '0;
          row_d   = '0;
          subX_d  = '0;
          subY_d  = '0;
        end
      end
      S_SNAP: begin
        load    = 1'b1;
        state_d = S_DRAW;
      end
      S_DRAW: begin
        if (wrEn_q && wr.wr_ready) begin
          if (wrAddr_q == AddrLast) begin
            wrEn_d  = 1'b0;
            state_d = S_FIN;
          end else begin
            load = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (load) begin
      wrEn_d   = 1'b1;
      wrAddr_d = addr_q;
      wrData_d = shadeRgb;
      addr_d   = addr_q + 19'd1;
      pixX_d   = stepX;
      pixY_d   = stepY;
      col_d    = stepCol;
      row_d    = stepRow;
      subX_d   = stepSubX;
      subY_d   = stepSubY;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      board_q  <= '0;
      pixX_q   <= '0;
      pixY_q   <= '0;
      addr_q   <= '0;
      col_q    <= '0;
      row_q    <= '0;
      subX_q   <= '0;
      subY_q   <= '0;
      wrAddr_q <= '0;
      wrData_q <= '0;
      wrEn_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      board_q  <= board_d;
      pixX_q   <= pixX_d;
      pixY_q   <= pixY_d;
      addr_q   <= addr_d;
      col_q    <= col_d;
      row_q    <= row_d;
      subX_q   <= subX_d;
      subY_q   <= subY_d;
      wrAddr_q <= wrAddr_d;
      wrData_q <= wrData_d;
      wrEn_q   <= wrEn_d;
    end
  end

  assign wr.wr_addr = wrAddr_q;
  assign wr.wr_data = wrData_q;
  assign wr.wr_en   = wrEn_q;
  assign busy       = (state_q != S_IDLE);
  assign done       = (state_q == S_FIN);

endmodule
